sequential_multiplier: RTL

SEQUENTIAL_MULTIPLIER -- requirements
Module: sequential_multiplier

---
 rtl/sequential_multiplier.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sequential_multiplier.sv
// Iterative digit-serial multiplier with optional accumulate.
// An operation retires DIGIT multiplier bits per cycle, then spends one
// cycle on sign correction and accumulation before presenting a registered
// result behind a valid/ready handshake.
// The operation-select port is named op_type because 'type' is a reserved
// word in SystemVerilog.
module sequential_multiplier #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op_type,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    input  logic [WIDTH-1:0]     d,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 n,
    output logic                 z
);

    localparam int ITER = WIDTH / DIGIT;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0]      LAST_CNT = CW'(ITER - 1);
    localparam logic [CW-1:0]      ZERO_CNT = '0;
    localparam logic [WIDTH-1:0]   ZERO_W   = '0;
    localparam logic [2*WIDTH-1:0] ZERO_2W  = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q,     state_d;
    logic [CW-1:0]        cnt_q,       cnt_d;
    logic [2*WIDTH-1:0]   mcand_q,     mcand_d;
    logic [WIDTH-1:0]     mplier_q,    mplier_d;
    logic [2*WIDTH-1:0]   prod_q,      prod_d;
    logic [2*WIDTH-1:0]   acc_q,       acc_d;
    logic                 sign_q,      sign_d;
    logic                 long_q,      long_d;
    logic [2*WIDTH-1:0]   result_q,    result_d;
    logic                 n_q,         n_d;
    logic                 z_q,         z_d;
    logic                 in_ready_q,  in_ready_d;
    logic                 out_valid_q, out_valid_d;

    logic                 signed_op_s;
    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic [2*WIDTH-1:0]   acc_in_s;
    logic [2*WIDTH-1:0]   digit_s;
    logic [2*WIDTH-1:0]   partial_s;
    logic [2*WIDTH-1:0]   signed_prod_s;
    logic [2*WIDTH-1:0]   sum_s;

    // Datapath helpers: operand magnitudes, accumulate term, digit partial product, final sum.
    always_comb begin
        signed_op_s = op_type[2] & op_type[1];

        if (signed_op_s && a[WIDTH-1]) begin
            a_mag_s = ZERO_W - a;
        end else begin
            a_mag_s = a;
        end

        if (signed_op_s && b[WIDTH-1]) begin
            b_mag_s = ZERO_W - b;
        end else begin
            b_mag_s = b;
        end

        // MLA adds c to the low word; the long accumulating forms add {c,d}.
        if (op_type == 3'b001) begin
            acc_in_s = {ZERO_W, c};
        end else if (op_type[2] && op_type[0]) begin
            acc_in_s = {c, d};
        end else begin
            acc_in_s = ZERO_2W;
        end

        digit_s   = {{(2*WIDTH-DIGIT){1'b0}}, mplier_q[DIGIT-1:0]};
        partial_s = mcand_q * digit_s;

        if (sign_q) begin
            signed_prod_s = ZERO_2W - prod_q;
        end else begin
            signed_prod_s = prod_q;
        end
        sum_s = signed_prod_s + acc_q;
    end

    // Next-state and next-register values for the IDLE/CALC/ACC/DONE sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        sign_d      = sign_q;
        long_d      = long_q;
        result_d    = result_q;
        n_d         = n_q;
        z_d         = z_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d    = {ZERO_W, a_mag_s};
                    mplier_d   = b_mag_s;
                    prod_d     = ZERO_2W;
                    acc_d      = acc_in_s;
                    sign_d     = signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                    long_d     = op_type[2];
                    cnt_d      = ZERO_CNT;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            CALC: begin
                // Shifting the multiplicand left keeps each digit's weight implicit.
                prod_d   = prod_q + partial_s;
                mcand_d  = mcand_q << DIGIT;
                mplier_d = mplier_q >> DIGIT;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = ZERO_CNT;
                    state_d = ACC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACC: begin
                if (long_q) begin
                    result_d = sum_s;
                    n_d      = sum_s[2*WIDTH-1];
                    z_d      = (sum_s == ZERO_2W);
                end else begin
                    result_d = {ZERO_W, sum_s[WIDTH-1:0]};
                    n_d      = sum_s[WIDTH-1];
                    z_d      = (sum_s[WIDTH-1:0] == ZERO_W);
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= ZERO_CNT;
            mcand_q     <= ZERO_2W;
            mplier_q    <= ZERO_W;
            prod_q      <= ZERO_2W;
            acc_q       <= ZERO_2W;
            sign_q      <= 1'b0;
            long_q      <= 1'b0;
            result_q    <= ZERO_2W;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            sign_q      <= sign_d;
            long_q      <= long_d;
            result_q    <= result_d;
            n_q         <= n_d;
            z_q         <= z_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign n         = n_q;
    assign z         = z_q;

endmodule
